// File: rtl/hw_stack.sv
// Parametrised LIFO stack with dual-pop, replace/reduce ops,
// registered top/second shadows and sticky error flags.
module hw_stack #(
  parameter int  WIDTH_DATA = 16,
  parameter int  DEPTH      = 16,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  pop2,
  input  logic [WIDTH_DATA-1:0] data_in,
  input  logic                  clear_err,
  output logic [WIDTH_DATA-1:0] top,
  output logic [WIDTH_DATA-1:0] second,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH_DATA-1:0] mem [DEPTH];

  logic [CW-1:0]         count_q, count_d;
  logic [WIDTH_DATA-1:0] top_q, top_d;
  logic [WIDTH_DATA-1:0] second_q, second_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic [31:0]           c;
  logic                  we;
  logic [AW-1:0]         widx;
  logic [WIDTH_DATA-1:0] rd3, rd4;
  logic                  ovf_evt, unf_evt;

  always_comb begin
    c        = 32'(count_q);
    rd3      = mem[AW'(c - 32'd3)];
    rd4      = mem[AW'(c - 32'd4)];
    count_d  = count_q;
    top_d    = top_q;
    second_d = second_q;
    we       = 1'b0;
    widx     = AW'(c);
    ovf_evt  = 1'b0;
    unf_evt  = 1'b0;
    priority case (1'b1)
      pop2: begin
        if (c < 32'd2) begin
          unf_evt = 1'b1;
        end else if (push) begin
          we       = 1'b1;
          widx     = AW'(c - 32'd2);
          count_d  = count_q - CW'(1);
          top_d    = data_in;
          second_d = (c > 32'd2) ? rd3 : '0;
        end else begin
          count_d  = count_q - CW'(2);
          top_d    = (c > 32'd2) ? rd3 : '0;
          second_d = (c > 32'd3) ? rd4 : '0;
        end
      end
      pop: begin
        if (c < 32'd1) begin
          unf_evt = 1'b1;
        end else if (push) begin
          we    = 1'b1;
          widx  = AW'(c - 32'd1);
          top_d = data_in;
        end else begin
          // Old second is already the new top; read ahead for the new second.
          count_d  = count_q - CW'(1);
          top_d    = second_q;
          second_d = (c > 32'd2) ? rd3 : '0;
        end
      end
      push: begin
        if (c == 32'(DEPTH)) begin
          ovf_evt = 1'b1;
        end else begin
          we       = 1'b1;
          count_d  = count_q + CW'(1);
          top_d    = data_in;
          second_d = top_q;
        end
      end
      default: ;
    endcase
    overflow_d  = ovf_evt | (overflow_q & ~clear_err);
    underflow_d = unf_evt | (underflow_q & ~clear_err);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      top_q       <= '0;
      second_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      top_q       <= top_d;
      second_q    <= second_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !reset) mem[widx] <= data_in;
  end

  assign top       = top_q;
  assign second    = second_q;
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_hw_stack.sv
// Bench for hw_stack: two instances (depth 4 and 3) on shared stimulus,
// checked against a queue-style reference model.
module tb_hw_stack;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, push, pop, pop2, clear_err;
  logic [15:0] data_in;

  logic [15:0] a_top, a_second;
  logic [2:0]  a_count;
  logic        a_empty, a_full, a_ovf, a_unf;

  logic [10:0] b_top, b_second;
  logic [1:0]  b_count;
  logic        b_empty, b_full, b_ovf, b_unf;

  hw_stack #(.WIDTH_DATA(16), .DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .pop2(pop2),
    .data_in(data_in), .clear_err(clear_err),
    .top(a_top), .second(a_second), .count(a_count),
    .empty(a_empty), .full(a_full),
    .overflow(a_ovf), .underflow(a_unf)
  );

  hw_stack #(.WIDTH_DATA(11), .DEPTH(3)) dut_b (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .pop2(pop2),
    .data_in(data_in[10:0]), .clear_err(clear_err),
    .top(b_top), .second(b_second), .count(b_count),
    .empty(b_empty), .full(b_full),
    .overflow(b_ovf), .underflow(b_unf)
  );

  int checks = 0;
  int errors = 0;

  int          m_cnt  [2];
  logic [15:0] m_st   [2][0:3];
  bit          m_ovf  [2];
  bit          m_unf  [2];
  int          m_dep  [2] = '{4, 3};
  logic [15:0] m_mask [2] = '{16'hFFFF, 16'h07FF};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_top(input int i);
    return (m_cnt[i] >= 1) ? 32'(m_st[i][m_cnt[i]-1]) : 32'd0;
  endfunction

  function automatic logic [31:0] m_sec(input int i);
    return (m_cnt[i] >= 2) ? 32'(m_st[i][m_cnt[i]-2]) : 32'd0;
  endfunction

  // Pop n entries, then push: replace and reduce fall out naturally.
  task automatic model_step(input int i, input bit p, input int n,
                            input logic [15:0] d, input bit clr,
                            input bit rst);
    if (rst) begin
      m_cnt[i] = 0;
      m_ovf[i] = 1'b0;
      m_unf[i] = 1'b0;
    end else begin
      if (clr) begin
        m_ovf[i] = 1'b0;
        m_unf[i] = 1'b0;
      end
      if (n > m_cnt[i]) begin
        m_unf[i] = 1'b1;
      end else if (n == 0 && p && m_cnt[i] == m_dep[i]) begin
        m_ovf[i] = 1'b1;
      end else begin
        m_cnt[i] -= n;
        if (p) begin
          m_st[i][m_cnt[i]] = d & m_mask[i];
          m_cnt[i]++;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " a.count"},  32'(a_count),  32'(m_cnt[0]));
    chk({tag, " a.top"},    32'(a_top),    m_top(0));
    chk({tag, " a.second"}, 32'(a_second), m_sec(0));
    chk({tag, " a.empty"},  32'(a_empty),  32'(m_cnt[0] == 0));
    chk({tag, " a.full"},   32'(a_full),   32'(m_cnt[0] == 4));
    chk({tag, " a.ovf"},    32'(a_ovf),    32'(m_ovf[0]));
    chk({tag, " a.unf"},    32'(a_unf),    32'(m_unf[0]));
    chk({tag, " b.count"},  32'(b_count),  32'(m_cnt[1]));
    chk({tag, " b.top"},    32'(b_top),    m_top(1));
    chk({tag, " b.second"}, 32'(b_second), m_sec(1));
    chk({tag, " b.empty"},  32'(b_empty),  32'(m_cnt[1] == 0));
    chk({tag, " b.full"},   32'(b_full),   32'(m_cnt[1] == 3));
    chk({tag, " b.ovf"},    32'(b_ovf),    32'(m_ovf[1]));
    chk({tag, " b.unf"},    32'(b_unf),    32'(m_unf[1]));
  endtask

  task automatic step(input string tag, input bit p, input bit pp,
                      input bit p2, input logic [15:0] d,
                      input bit clr, input bit rst);
    int n;
    push      = p;
    pop       = pp;
    pop2      = p2;
    data_in   = d;
    clear_err = clr;
    reset     = rst;
    @(posedge clk);
    n = p2 ? 2 : (pp ? 1 : 0);
    model_step(0, p, n, d, clr, rst);
    model_step(1, p, n, d, clr, rst);
    #1;
    check_all(tag);
  endtask

  initial begin
    int r;
    bit p, pp, p2, clr, rst;

    // ALU-style reduce
    step("rst1",   0, 0, 0, 16'd0, 0, 1);
    step("psh5",   1, 0, 0, 16'd5, 0, 0);
    step("psh2",   1, 0, 0, 16'd2, 0, 0);
    chk("p1 second", 32'(a_second), 32'd5);
    step("reduce", 1, 0, 1, 16'd7, 0, 0);
    chk("p1 count", 32'(a_count), 32'd1);
    chk("p1 top",   32'(a_top),   32'd7);
    chk("p1 unf",   32'(a_unf),   32'd0);

    // full / overflow / replace at full
    step("rst2", 0, 0, 0, 16'd0, 0, 1);
    for (int k = 1; k <= 4; k++) step("fill", 1, 0, 0, 16'(k), 0, 0);
    chk("p2 full", 32'(a_full), 32'd1);
    step("ovf",  1, 0, 0, 16'd9, 0, 0);
    chk("p2 ovf", 32'(a_ovf), 32'd1);
    chk("p2 top", 32'(a_top), 32'd4);
    step("repl", 1, 1, 0, 16'd8, 0, 0);
    chk("p2 rtop",  32'(a_top),  32'd8);
    chk("p2 rfull", 32'(a_full), 32'd1);
    step("clr",  0, 0, 0, 16'd0, 1, 0);
    chk("p2 clr", 32'(a_ovf), 32'd0);

    // underflow cases
    step("rst3",   0, 0, 0, 16'd0, 0, 1);
    step("pop_e",  0, 1, 0, 16'd0, 0, 0);
    step("repl_e", 1, 1, 0, 16'd3, 0, 0);
    chk("p3 top", 32'(a_top), 32'd0);
    step("psh6",   1, 0, 0, 16'd6, 0, 0);
    step("pop2_1", 0, 0, 1, 16'd0, 0, 0);
    chk("p3 unf", 32'(a_unf),   32'd1);
    chk("p3 cnt", 32'(a_count), 32'd1);
    step("clr_err_same", 0, 1, 1, 16'd0, 1, 0);
    chk("p3 err wins", 32'(a_unf), 32'd1);

    // pop2 read-ahead then pop to empty
    step("rst4", 0, 0, 0, 16'd0, 0, 1);
    step("p10",  1, 0, 0, 16'd10, 0, 0);
    step("p20",  1, 0, 0, 16'd20, 0, 0);
    step("p30",  1, 0, 0, 16'd30, 0, 0);
    step("pop2", 0, 0, 1, 16'd0, 0, 0);
    chk("p4 top", 32'(a_top), 32'd10);
    step("pop",  0, 1, 0, 16'd0, 0, 0);
    chk("p4 empty", 32'(a_empty), 32'd1);

    // 11-bit return stack
    step("rst5", 0, 0, 0, 16'd0, 0, 1);
    step("r5a",  1, 0, 0, 16'd5, 0, 0);
    step("r5b",  1, 0, 0, 16'd5, 0, 0);
    step("rrep", 1, 1, 0, 16'h07FF, 0, 0);
    chk("p5 top", 32'(b_top), 32'h7FF);
    step("rpa",  0, 1, 0, 16'd0, 0, 0);
    step("rpb",  0, 1, 0, 16'd0, 0, 0);
    chk("p5 empty", 32'(b_empty), 32'd1);

    // reset with push pending
    for (int k = 0; k < 3; k++) step("m", 1, 0, 0, 16'(k + 40), 0, 0);
    step("rst_push", 1, 0, 0, 16'd99, 0, 1);
    chk("p6 cnt", 32'(a_count), 32'd0);
    step("psh4", 1, 0, 0, 16'd4, 0, 0);
    chk("p6 top", 32'(a_top), 32'd4);

    for (int k = 0; k < 600; k++) begin
      r   = int'($urandom_range(0, 99));
      p   = 1'b0;
      pp  = 1'b0;
      p2  = 1'b0;
      if (r < 45) p = 1'b1;
      else if (r < 70) pp = 1'b1;
      else if (r < 85) begin p2 = 1'b1; pp = 1'($urandom_range(0, 1)); end
      else if (r < 93) begin p = 1'b1; pp = 1'b1; end
      else if (r < 98) begin p = 1'b1; p2 = 1'b1; end
      clr = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 199) == 0);
      step("rnd", p, pp, p2, 16'($urandom), clr, rst);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
